// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Bus-initiator for the single-port data RAM. Accepts one
//               load/store at a time, holds the address in MAR and store
//               data in MDR, sequences ram_we/ram_re, waits out the RAM read
//               latency, and flags addresses beyond the 8-bit RAM space.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int READ_LATENCY = 1   // 1..7 cycles from ram_re sample to valid ram_rdata
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        rw,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [31:0] ram_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_FLT     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Wait-counter preload: RD_WAIT lasts READ_LATENCY cycles in total.
    localparam logic [2:0] C_WAIT_INIT = 3'(READ_LATENCY - 1);

    logic [2:0]  r_state, w_state_nxt;
    logic [7:0]  r_mar,   w_mar_nxt;
    logic [31:0] r_mdr,   w_mdr_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_fault, w_fault_nxt;
    logic [2:0]  r_cnt,   w_cnt_nxt;

    logic        w_addr_out_of_range;

    assign w_addr_out_of_range = |addr_in[31:8];

    // Register all controller state; clear wins over everything else.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_mar   <= 8'd0;
            r_mdr   <= 32'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mar   <= w_mar_nxt;
            r_mdr   <= w_mdr_nxt;
            r_rdata <= w_rdata_nxt;
            r_fault <= w_fault_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and datapath-register update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_mar_nxt   = r_mar;
        w_mdr_nxt   = r_mdr;
        w_rdata_nxt = r_rdata;
        w_fault_nxt = r_fault;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mar_nxt   = addr_in[7:0];
                    w_fault_nxt = w_addr_out_of_range;
                    if (w_addr_out_of_range) begin
                        w_state_nxt = S_FLT;
                    end else if (rw) begin
                        w_mdr_nxt   = wdata;
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                w_cnt_nxt   = C_WAIT_INIT;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    // Counter exhausted: RAM data is valid this cycle only.
                    w_rdata_nxt = ram_rdata;
                    w_state_nxt = S_DONE;
                end
            end
            S_WR:    w_state_nxt = S_DONE;
            S_FLT:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore decode of strobes and status; RAM bus always mirrors MAR/MDR.
    assign ram_we    = (r_state == S_WR);
    assign ram_re    = (r_state == S_RD_REQ);
    assign busy      = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                       (r_state == S_WR)     || (r_state == S_FLT);
    assign done      = (r_state == S_DONE);
    assign ram_addr  = r_mar;
    assign ram_wdata = r_mdr;
    assign rdata     = r_rdata;
    assign fault     = r_fault;

endmodule
`default_nettype wire
